// File: rtl/sig_capture_core.sv
// Multi-channel logic-analyser capture core: circular sample buffer with a masked
// level/edge trigger, programmable pre-trigger depth and a linearised read port.
module sig_capture_core #(
  parameter int unsigned CH_WIDTH = 8,
  parameter int unsigned DEPTH    = 1024,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CH_WIDTH-1:0] data_i,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic [CH_WIDTH-1:0] trig_mask_i,
  input  logic [CH_WIDTH-1:0] trig_value_i,
  input  logic                trig_edge_i,
  input  logic [AW-1:0]       pretrig_i,
  input  logic [AW-1:0]       rd_addr_i,
  output logic [CH_WIDTH-1:0] rd_data_o,
  output logic                busy_o,
  output logic                triggered_o,
  output logic                done_o,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              state;
  logic [CH_WIDTH-1:0] mask_q;
  logic [CH_WIDTH-1:0] value_q;
  logic                edge_q;
  logic [AW-1:0]       pt_q;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       pre_cnt;
  logic [AW-1:0]       post_cnt;
  logic [AW-1:0]       start_ptr;
  logic                prev_match;

  logic [CH_WIDTH-1:0] mem [DEPTH];

  logic                match_c;
  logic                trig_c;
  logic                wr_en_c;
  logic [AW-1:0]       post_load_c;
  logic [AW-1:0]       rd_idx_c;

  // Trigger decision works on the same sample that is being written.
  always_comb begin
    match_c     = ((data_i ^ value_q) & mask_q) == '0;
    trig_c      = edge_q ? (match_c & ~prev_match) : match_c;
    wr_en_c     = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    post_load_c = AW'(DEPTH - 1) - pt_q;
    rd_idx_c    = start_ptr + rd_addr_i;
  end

  assign state_o = 3'(state);

  // Capture control; pretrig_i is AW bits wide so PT can never exceed DEPTH-1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mask_q      <= '0;
      value_q     <= '0;
      edge_q      <= 1'b0;
      pt_q        <= '0;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      start_ptr   <= '0;
      prev_match  <= 1'b0;
      busy_o      <= 1'b0;
      triggered_o <= 1'b0;
      done_o      <= 1'b0;
    end else if (abort_i) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      triggered_o <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm_i) begin
            mask_q      <= trig_mask_i;
            value_q     <= trig_value_i;
            edge_q      <= trig_edge_i;
            pt_q        <= pretrig_i;
            wr_ptr      <= '0;
            pre_cnt     <= '0;
            prev_match  <= 1'b1;
            triggered_o <= 1'b0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            state       <= (pretrig_i != '0) ? PRE : WAIT_TRIG;
          end
        end
        PRE: begin
          wr_ptr     <= wr_ptr + AW'(1);
          pre_cnt    <= pre_cnt + AW'(1);
          prev_match <= match_c;
          if (pre_cnt == pt_q - AW'(1)) state <= WAIT_TRIG;
        end
        WAIT_TRIG: begin
          wr_ptr     <= wr_ptr + AW'(1);
          prev_match <= match_c;
          if (trig_c) begin
            start_ptr   <= wr_ptr - pt_q;
            post_cnt    <= post_load_c;
            triggered_o <= 1'b1;
            if (post_load_c == '0) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          wr_ptr   <= wr_ptr + AW'(1);
          post_cnt <= post_cnt - AW'(1);
          if (post_cnt == AW'(1)) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_c) mem[wr_ptr] <= data_i;
  end

  // Linearised read port, oldest sample at logical address 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_o <= '0;
    else       rd_data_o <= mem[rd_idx_c];
  end

endmodule

// File: tb/tb_sig_capture_core.sv
// Directed bench for sig_capture_core at CH_WIDTH=8, DEPTH=16.
module tb_sig_capture_core;

  localparam int unsigned CW = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] data;
  logic          arm;
  logic          abort;
  logic [CW-1:0] trig_mask;
  logic [CW-1:0] trig_value;
  logic          trig_edge;
  logic [AW-1:0] pretrig;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [2:0]    state;

  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] stim [64];
  logic [CW-1:0] rd   [16];
  int            n;
  bit            saw_post;
  bit            timed_out;

  sig_capture_core #(.CH_WIDTH(CW), .DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .arm_i(arm), .abort_i(abort),
    .trig_mask_i(trig_mask), .trig_value_i(trig_value), .trig_edge_i(trig_edge),
    .pretrig_i(pretrig), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .busy_o(busy), .triggered_o(triggered), .done_o(done), .state_o(state)
  );

  always #5 clk = ~clk;

  // Pulse arm with a trigger configuration; returns just after the arm edge.
  task automatic arm_cfg(input logic [AW-1:0] pt, input logic [CW-1:0] mask,
                         input logic [CW-1:0] value, input logic edg);
    @(negedge clk);
    pretrig = pt; trig_mask = mask; trig_value = value; trig_edge = edg; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Feed stim[first..] one sample per clock until done_o or the cycle budget runs out.
  task automatic run(input int first);
    n = first; saw_post = 1'b0; timed_out = 1'b1;
    while (n < 200) begin
      data = (n < 64) ? stim[n[5:0]] : '0;
      @(negedge clk);
      n++;
      if (state == 3'd3) saw_post = 1'b1;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rd_addr = AW'(a);
      @(negedge clk);
      rd[a] = rd_data;
    end
  endtask

  task automatic fill_counter();
    for (int i = 0; i < 64; i++) stim[i] = CW'(i);
  endtask

  task automatic test_reset();
    tests++;
    if ({state, busy, triggered, done, rd_data} !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs: got st=%0d b=%b t=%b d=%b rd=%h required all 0",
               state, busy, triggered, done, rd_data);
    end
  endtask

  task automatic test_basic();
    fill_counter();
    arm_cfg(4'd4, 8'hFF, 8'h0A, 1'b0);
    run(0);
    tests++;
    if (timed_out || n != 22) begin
      fails++;
      $display("FAIL basic_done_cycle: got n=%0d timeout=%b required n=22", n, timed_out);
    end
    tests++;
    if ({busy, triggered, done, state} !== {3'b011, 3'd4}) begin
      fails++;
      $display("FAIL basic_flags: got b=%b t=%b d=%b st=%0d required 0 1 1 4",
               busy, triggered, done, state);
    end
    read_all();
    for (int a = 0; a < 16; a++) begin
      tests++;
      if (rd[a] !== CW'(6 + a)) begin
        fails++;
        $display("FAIL basic_rd[%0d]: got %h required %h", a, rd[a], CW'(6 + a));
      end
    end
  endtask

  task automatic test_no_pretrig();
    fill_counter();
    arm_cfg(4'd0, 8'h00, 8'h0A, 1'b0);
    data = stim[0];
    tests++;
    if ({state, triggered} !== {3'd2, 1'b0}) begin
      fails++;
      $display("FAIL nopt_after_arm: got st=%0d t=%b required st=2 t=0", state, triggered);
    end
    @(negedge clk);
    tests++;
    if ({state, triggered} !== {3'd3, 1'b1}) begin
      fails++;
      $display("FAIL nopt_trig_rise: got st=%0d t=%b required st=3 t=1", state, triggered);
    end
    run(1);
    tests++;
    if (timed_out || n != 16) begin
      fails++;
      $display("FAIL nopt_done_cycle: got n=%0d timeout=%b required n=16", n, timed_out);
    end
    read_all();
    for (int a = 0; a < 16; a++) begin
      tests++;
      if (rd[a] !== CW'(a)) begin
        fails++;
        $display("FAIL nopt_rd[%0d]: got %h required %h", a, rd[a], CW'(a));
      end
    end
  endtask

  task automatic test_edge();
    logic [CW-1:0] exp;
    for (int i = 0; i < 64; i++) stim[i] = (i >= 20 && i < 23) ? 8'h00 : 8'h0A;
    data = 8'h0A;
    arm_cfg(4'd4, 8'hFF, 8'h0A, 1'b1);
    run(0);
    tests++;
    if (timed_out || n != 35) begin
      fails++;
      $display("FAIL edge_done_cycle: got n=%0d timeout=%b required n=35", n, timed_out);
    end
    read_all();
    for (int a = 0; a < 16; a++) begin
      exp = (a >= 1 && a <= 3) ? 8'h00 : 8'h0A;
      tests++;
      if (rd[a] !== exp) begin
        fails++;
        $display("FAIL edge_rd[%0d]: got %h required %h", a, rd[a], exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [CW-1:0] exp;
    fill_counter();
    stim[41] = 8'hAA;
    arm_cfg(4'd4, 8'hFF, 8'hAA, 1'b0);
    run(0);
    tests++;
    if (timed_out || n != 53) begin
      fails++;
      $display("FAIL wrap_done_cycle: got n=%0d timeout=%b required n=53", n, timed_out);
    end
    read_all();
    for (int a = 0; a < 16; a++) begin
      exp = (a == 4) ? 8'hAA : CW'(37 + a);
      tests++;
      if (rd[a] !== exp) begin
        fails++;
        $display("FAIL wrap_rd[%0d]: got %h required %h", a, rd[a], exp);
      end
    end
  endtask

  task automatic test_abort_full_pretrig();
    int i;
    fill_counter();
    arm_cfg(4'd4, 8'hFF, 8'h0A, 1'b0);
    i = 0;
    while (state != 3'd3 && i < 60) begin
      data = stim[i[5:0]];
      @(negedge clk);
      i++;
    end
    tests++;
    if (state !== 3'd3) begin
      fails++;
      $display("FAIL abort_reach_post: got st=%0d required 3", state);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if ({state, busy, triggered, done} !== 6'd0) begin
      fails++;
      $display("FAIL abort_idle: got st=%0d b=%b t=%b d=%b required all 0",
               state, busy, triggered, done);
    end
    fill_counter();
    arm_cfg(4'd15, 8'hFF, 8'h20, 1'b0);
    run(0);
    tests++;
    if (timed_out || n != 33 || saw_post) begin
      fails++;
      $display("FAIL fullpt_done: got n=%0d timeout=%b post_seen=%b required n=33 no post",
               n, timed_out, saw_post);
    end
    read_all();
    for (int a = 0; a < 16; a++) begin
      tests++;
      if (rd[a] !== CW'(17 + a)) begin
        fails++;
        $display("FAIL fullpt_rd[%0d]: got %h required %h", a, rd[a], CW'(17 + a));
      end
    end
  endtask

  task automatic test_busy_arm_and_reset();
    data = 8'h00;
    arm_cfg(4'd4, 8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({state, busy} !== {3'd2, 1'b1}) begin
      fails++;
      $display("FAIL busy_arm_ignored: got st=%0d b=%b required st=2 b=1", state, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({state, busy, triggered, done, rd_data} !== 14'd0) begin
      fails++;
      $display("FAIL midrun_reset: got st=%0d b=%b t=%b d=%b rd=%h required all 0",
               state, busy, triggered, done, rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (state !== 3'd0) begin
      fails++;
      $display("FAIL post_reset_idle: got st=%0d required 0", state);
    end
    fill_counter();
    arm_cfg(4'd4, 8'hFF, 8'h0A, 1'b0);
    run(0);
    read_all();
    tests++;
    if (timed_out || n != 22 || rd[4] !== 8'h0A || rd[0] !== 8'h06) begin
      fails++;
      $display("FAIL rearm_after_reset: got n=%0d rd0=%h rd4=%h required n=22 rd0=06 rd4=0a",
               n, rd[0], rd[4]);
    end
  endtask

  initial begin
    rst = 1'b1; data = '0; arm = 1'b0; abort = 1'b0;
    trig_mask = '0; trig_value = '0; trig_edge = 1'b0; pretrig = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_basic();
    test_no_pretrig();
    test_edge();
    test_wrap();
    test_abort_full_pretrig();
    test_busy_arm_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
